// File: rtl/result_bcd_display.sv
// result_bcd_display: iterative double-dabble binary-to-BCD converter with blanked 7-segment outputs
module result_bcd_display #(
   parameter int N      = 4,
   parameter int DIGITS = 3,
   parameter int BLANK  = 1
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start,
   input  logic [2*N-1:0]        resultado,
   output logic                  busy,
   output logic                  done,
   output logic                  ovf,
   output logic [4*DIGITS-1:0]   bcd,
   output logic [7*DIGITS-1:0]   seg
);
   localparam int W  = 2 * N;
   localparam int CW = $clog2(W) + 1;
   localparam int BW = 4 * DIGITS;
   localparam int SW = 7 * DIGITS;

   function automatic logic [63:0] pow10(input int e);
      pow10 = 64'd1;
      for (int k = 0; k < e; k++) pow10 = pow10 * 64'd10;
   endfunction

   localparam logic [63:0] MAXV = pow10(DIGITS) - 64'd1;

   localparam logic [1:0] IDLE   = 2'd0;
   localparam logic [1:0] SHIFT  = 2'd1;
   localparam logic [1:0] FINISH = 2'd2;

   function automatic logic [6:0] seg7(input logic [3:0] d);
      case (d)
         4'd0:    seg7 = 7'h40;
         4'd1:    seg7 = 7'h79;
         4'd2:    seg7 = 7'h24;
         4'd3:    seg7 = 7'h30;
         4'd4:    seg7 = 7'h19;
         4'd5:    seg7 = 7'h12;
         4'd6:    seg7 = 7'h02;
         4'd7:    seg7 = 7'h78;
         4'd8:    seg7 = 7'h00;
         4'd9:    seg7 = 7'h10;
         default: seg7 = 7'h7F;
      endcase
   endfunction

   logic [1:0]    state;
   logic [W-1:0]  sh;
   logic [W-1:0]  cap;
   logic [BW-1:0] scratch;
   logic [BW-1:0] adj;
   logic [CW-1:0] cnt;
   logic [SW-1:0] seg_next;
   logic [SW-1:0] seg_rst;

   // add 3 to every scratch digit >= 5, each digit independently with no carry
   always_comb begin
      adj = scratch;
      for (int i = 0; i < DIGITS; i++)
         adj[4*i +: 4] = (scratch[4*i +: 4] >= 4'd5) ? scratch[4*i +: 4] + 4'd3 : scratch[4*i +: 4];
   end

   // decode digits, blanking a digit when it and everything above it is zero
   always_comb begin
      logic lead;
      lead     = 1'b1;
      seg_next = '0;
      seg_rst  = '0;
      for (int i = DIGITS - 1; i >= 0; i--) begin
         lead = lead & (scratch[4*i +: 4] == 4'd0);
         seg_next[7*i +: 7] = (BLANK != 0 && i > 0 && lead) ? 7'h7F : seg7(scratch[4*i +: 4]);
         seg_rst[7*i +: 7]  = (BLANK != 0 && i > 0) ? 7'h7F : 7'h40;
      end
   end

   // conversion FSM; shifting out the top scratch bit truncates the result modulo 10^DIGITS
   always_ff @(posedge clk) begin
      if (!reset) begin
         state   <= IDLE;
         busy    <= 1'b0;
         done    <= 1'b0;
         ovf     <= 1'b0;
         bcd     <= '0;
         seg     <= seg_rst;
         sh      <= '0;
         cap     <= '0;
         scratch <= '0;
         cnt     <= '0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: if (start) begin
               sh      <= resultado;
               cap     <= resultado;
               scratch <= '0;
               cnt     <= '0;
               busy    <= 1'b1;
               state   <= SHIFT;
            end
            SHIFT: begin
               {scratch, sh} <= {adj[BW-2:0], sh, 1'b0};
               cnt           <= cnt + CW'(1);
               if (cnt == CW'(W - 1)) state <= FINISH;
            end
            FINISH: begin
               bcd   <= scratch;
               seg   <= seg_next;
               ovf   <= 64'(cap) > MAXV;
               done  <= 1'b1;
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_result_bcd_display.sv
// tb_result_bcd_display: randomized and directed checks of three converter configurations against an arithmetic model
module tb_result_bcd_display;
   localparam int N = 4;
   localparam logic [6:0] TBL [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

   logic clk = 1'b0;
   logic reset, start;
   logic [7:0] resultado;
   logic b0, b1, b2, d0, d1, d2, o0, o1, o2;
   logic [11:0] bcd0, bcd1;
   logic [7:0]  bcd2;
   logic [20:0] seg0, seg1;
   logic [13:0] seg2;
   int n_chk = 0;
   int n_fail = 0;

   result_bcd_display #(.N(4), .DIGITS(3), .BLANK(1)) u0 (.clk(clk), .reset(reset), .start(start), .resultado(resultado),
      .busy(b0), .done(d0), .ovf(o0), .bcd(bcd0), .seg(seg0));
   result_bcd_display #(.N(4), .DIGITS(3), .BLANK(0)) u1 (.clk(clk), .reset(reset), .start(start), .resultado(resultado),
      .busy(b1), .done(d1), .ovf(o1), .bcd(bcd1), .seg(seg1));
   result_bcd_display #(.N(4), .DIGITS(2), .BLANK(1)) u2 (.clk(clk), .reset(reset), .start(start), .resultado(resultado),
      .busy(b2), .done(d2), .ovf(o2), .bcd(bcd2), .seg(seg2));

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
      n_chk++;
      if (got !== want) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, want);
      end
   endtask

   function automatic logic [31:0] mbcd(input int v, input int dig);
      logic [31:0] r = '0;
      for (int i = 0; i < dig; i++) r[4*i +: 4] = 4'((v / (10 ** i)) % 10);
      return r;
   endfunction

   function automatic logic [31:0] mseg(input int v, input int dig, input bit blk);
      logic [31:0] r = '0;
      int t = v % (10 ** dig);
      for (int i = 0; i < dig; i++) r[7*i +: 7] = (blk && i > 0 && t / (10 ** i) == 0) ? 7'h7F : TBL[(t / (10 ** i)) % 10];
      return r;
   endfunction

   task automatic chk_all(input string tag, input int v);
      chk({tag, "_bcd0"}, 32'(bcd0), mbcd(v, 3));
      chk({tag, "_seg0"}, 32'(seg0), mseg(v, 3, 1'b1));
      chk({tag, "_ovf0"}, 32'(o0), 32'(v > 999));
      chk({tag, "_bcd1"}, 32'(bcd1), mbcd(v, 3));
      chk({tag, "_seg1"}, 32'(seg1), mseg(v, 3, 1'b0));
      chk({tag, "_ovf1"}, 32'(o1), 32'(v > 999));
      chk({tag, "_bcd2"}, 32'(bcd2), mbcd(v, 2));
      chk({tag, "_seg2"}, 32'(seg2), mseg(v, 2, 1'b1));
      chk({tag, "_ovf2"}, 32'(o2), 32'(v > 99));
   endtask

   task automatic launch(input logic [7:0] v);
      start = 1'b1;
      resultado = v;
      @(posedge clk);
      #1;
      start = 1'b0;
      chk("busy_up", 32'({b0, b1, b2}), 32'h7);
      chk("done_low", 32'({d0, d1, d2}), 32'h0);
   endtask

   task automatic finish(input int v, input bit glitch);
      for (int j = 1; j <= 2*N + 1; j++) begin
         if (glitch && j == 3) begin start = 1'b1; resultado = 8'h63; end
         if (glitch && j == 4) begin start = 1'b0; resultado = 8'($urandom); end
         @(posedge clk);
         #1;
         chk("done_t", 32'({d0, d1, d2}), (j == 2*N + 1) ? 32'h7 : 32'h0);
         chk("busy_t", 32'({b0, b1, b2}), (j <= 2*N) ? 32'h7 : 32'h0);
      end
      chk_all("res", v);
   endtask

   task automatic settle(input int v);
      @(posedge clk);
      #1;
      chk("done_1cyc", 32'({d0, d1, d2}), 32'h0);
      chk("idle_busy", 32'({b0, b1, b2}), 32'h0);
      chk_all("hold", v);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      logic seen;
      int v;
      reset = 1'b0;
      start = 1'b0;
      resultado = '0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_busy", 32'({b0, b1, b2}), 32'h0);
      chk("rst_done", 32'({d0, d1, d2}), 32'h0);
      chk("rst_seg0", 32'(seg0), 32'({7'h7F, 7'h7F, 7'h40}));
      chk("rst_seg1", 32'(seg1), 32'({7'h40, 7'h40, 7'h40}));
      chk_all("rst", 0);
      reset = 1'b1;
      @(posedge clk);
      #1;
      launch(8'hE1); finish(225, 1'b0);
      chk("e1_bcd", 32'(bcd0), 32'h225);
      chk("e1_seg", 32'(seg0), 32'({7'h24, 7'h24, 7'h12}));
      settle(225);
      launch(8'h07); finish(7, 1'b0);
      chk("07_seg_blank", 32'(seg0), 32'({7'h7F, 7'h7F, 7'h78}));
      chk("07_seg_noblank", 32'(seg1), 32'({7'h40, 7'h40, 7'h78}));
      settle(7);
      launch(8'hFF); finish(255, 1'b0);
      chk("ff_bcd", 32'(bcd0), 32'h255);
      settle(255);
      launch(8'h09); finish(9, 1'b1);
      chk("ignored_start", 32'(bcd0), 32'h009);
      launch(8'h63); finish(99, 1'b0);
      chk("b2b_bcd", 32'(bcd0), 32'h099);
      chk("d2_99_bcd", 32'(bcd2), 32'h99);
      chk("d2_99_ovf", 32'(o2), 32'h0);
      settle(99);
      launch(8'hC8); finish(200, 1'b0);
      chk("c8_bcd2", 32'(bcd2), 32'h00);
      chk("c8_ovf2", 32'(o2), 32'h1);
      chk("c8_seg2", 32'(seg2), 32'({7'h7F, 7'h40}));
      settle(200);
      launch(8'h55);
      repeat (3) @(posedge clk);
      #1;
      reset = 1'b0;
      @(posedge clk);
      #1;
      chk("abort_busy", 32'({b0, b1, b2}), 32'h0);
      chk("abort_done", 32'({d0, d1, d2}), 32'h0);
      chk_all("abort", 0);
      reset = 1'b1;
      seen = 1'b0;
      repeat (2*N + 3) begin
         @(posedge clk);
         #1;
         seen = seen | d0 | d1 | d2;
      end
      chk("abort_no_done", 32'(seen), 32'h0);
      launch(8'h2A); finish(42, 1'b0);
      chk("2a_bcd", 32'(bcd0), 32'h042);
      settle(42);
      repeat (24) begin
         v = int'($urandom_range(0, 255));
         launch(8'(v));
         finish(v, 1'($urandom_range(0, 1)));
         settle(v);
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule

// File: doc/result_bcd_display.md
Name: result_bcd_display

Overview:
- Consumer end of the calculator result interface. Takes the registered 2N-bit calculator result and converts it to decimal.
- Conversion is an iterative shift-add-3 (double-dabble) binary-to-BCD conversion.
- Drives one active-low 7-segment pattern per decimal digit, with leading-zero blanking.
- Sits between the calculator output register and the board HEX displays; a start/busy/done handshake lets a top-level controller request refreshes.

Parameters:
- N, 4: operand width; input result width is 2N.
- DIGITS, 3: number of decimal digits/displays produced (DIGITS*4 BCD bits).
- BLANK, 1: 1 = blank leading zero digits; 0 = show all digits.

Ports:
- clk  input  1  system clock, all state on rising edge.
- reset  input  1  synchronous, active-low reset.
- start  input  1  conversion request, sampled only in IDLE.
- resultado  input  2N  unsigned binary result, captured on the accepted start edge.
- busy  output  1  high while a conversion is in progress.
- done  output  1  one-cycle pulse when bcd/seg/ovf update.
- ovf  output  1  captured value > 10^DIGITS-1.
- bcd  output  4*DIGITS  packed BCD, digit 0 (units) in bits [3:0].
- seg  output  7*DIGITS  active-low segments per digit, {g,f,e,d,c,b,a}; digit 0 in bits [6:0].

Behaviour:
- Reset (reset==0 at a clk edge):
  - FSM goes to IDLE; busy=0, done=0, ovf=0, bcd=0.
  - seg digit0=7'h40 ("0"); other digits 7'h7F (blank) if BLANK=1, else 7'h40.
  - Reset takes priority over everything. A conversion in progress is aborted and produces no done.
- FSM states: IDLE, SHIFT, FINISH.
- IDLE:
  - On start=1: load shift register with resultado, clear BCD scratch, counter=0, busy=1, go SHIFT.
  - start=0: hold.
- SHIFT (exactly 2N cycles):
  - Each cycle, every scratch BCD digit >=5 gets +3.
  - Then {scratch, shiftreg} is shifted left by 1.
  - Counter increments; after iteration 2N-1 go FINISH.
- FINISH (1 cycle):
  - bcd <= scratch; seg <= decoded digits; ovf <= (captured value > 10^DIGITS-1); done=1; busy=0; go IDLE.
- Latency: start accepted at edge k -> done high in the cycle after edge k+2N+1. For N=4 that is 10 edges from acceptance, i.e. 2N+2 cycles.
- Back-to-back: busy drops with done. start may be asserted in the done cycle and is accepted on the next edge (IDLE).
- start while busy or FINISH: ignored, not queued. resultado changes during conversion have no effect.
- bcd/seg/ovf hold their last values between conversions; they change only in FINISH or reset.
- Overflow (value >= 10^DIGITS):
  - Upper carries are discarded; bcd = value mod 10^DIGITS; ovf=1.
  - Blanking still applies to the truncated digits.
- Segment map (active-low, hex): 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78, 8=00, 9=10, blank=7F.
- BCD digits >9 cannot occur; decoder default is 7F.
- Blanking (BLANK=1):
  - Digit i>0 is blank iff it and all higher digits are 0.
  - Digit 0 is never blanked.
- Widths:
  - Scratch is 4*DIGITS bits.
  - Counter width is clog2(2N)+1; it must not wrap before 2N.
  - Add-3 is done per 4-bit digit with no carry into the next digit.

Test Plan:
- Reset with N=4, DIGITS=3, BLANK=1 -> busy=0, done=0, bcd=12'h000, seg={7F,7F,40}.
- resultado=8'hE1 (225), start pulse -> busy next cycle, done exactly one cycle wide after 2N+2 cycles. bcd=12'h225, seg={24,24,12}, ovf=0.
- resultado=8'h07 -> bcd=12'h007, seg={7F,7F,78}. Repeat with BLANK=0 -> seg={40,40,78}. Also resultado=8'hFF -> bcd=12'h255.
- start at 8'h09, re-pulse start with resultado=8'h63 mid-SHIFT -> second start ignored, result bcd=12'h009. Then start in done cycle with 8'h63 -> accepted, bcd=12'h099.
- DIGITS=2, resultado=8'hC8 (200) -> bcd=8'h00, ovf=1, seg={7F,40}. resultado=8'h63 -> bcd=8'h99, ovf=0.
- Assert reset for one edge during SHIFT -> no done pulse, outputs return to reset values. A subsequent start with 8'h2A yields bcd=12'h042.
